dw_line_buffer: RTL and testbench

- Upstream feeder of the depthwise 3x3 window generator.
- Accepts a raster pixel stream with one pixel per cycle, carrying all channels in parallel, and stores the previous two image rows in on-chip line buffers.
- For each accepted pixel it emits the vertically aligned 3-pixel column (row r-2, r-1, r) for every channel, packed exactly as the window generator consumes it.

---
 rtl/dw_pkg.sv | 18 +
 rtl/dw_lb_bank.sv | 26 ++
 rtl/dw_line_buffer.sv | 186 ++++++++++++++++++
 tb/tb_dw_line_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dw_pkg.sv
// Shared definitions for the depthwise 3x3 datapath: default sizes, the line
// buffer fill state and the packed (channel, row) slot offset.
package dw_pkg;

   localparam int DW_DATA_WIDTH = 8;
   localparam int DW_CH         = 18;

   typedef enum logic [0:0] {
      ST_FILL   = 1'b0,
      ST_STREAM = 1'b1
   } dw_state_e;

   // Bit offset of channel j, window row k inside a packed 3-row column.
   function automatic int dw_slot_off(input int j, input int k, input int data_width);
      return (j * 3 + k) * data_width;
   endfunction

endpackage

// File: rtl/dw_lb_bank.sv
// One line buffer bank: asynchronous read of the addressed entry with the write
// landing on the clock edge, so the same-cycle read returns the previous row.
module dw_lb_bank #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 144,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   // Storage write, contents deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

endmodule

// File: rtl/dw_line_buffer.sv
// Two-row line buffer feeding the depthwise 3x3 window generator; emits the
// vertical (r-2, r-1, r) column per accepted pixel. Optional top zero padding
// is enabled by defining DW_LB_ZERO_PAD_EN.
module dw_line_buffer
   import dw_pkg::*;
#(
   parameter int CH         = DW_CH,
   parameter int DATA_WIDTH = DW_DATA_WIDTH,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int COL_W      = $clog2(IMG_WIDTH),
   parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CH*DATA_WIDTH-1:0]   data_in,
   input  logic                       valid_in,
   input  logic                       sof_in,
   output logic [CH*3*DATA_WIDTH-1:0] data_out,
   output logic                       valid_out,
   output logic [COL_W-1:0]           col_out,
   output logic                       eol_out,
   output logic                       eof_out
);

   localparam int PW = CH * DATA_WIDTH;
   localparam int OW = CH * 3 * DATA_WIDTH;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   logic [COL_W-1:0] col_q, col_d, eff_col_s;
   logic [ROW_W-1:0] row_q, row_d, eff_row_s;
   dw_state_e        state_q, state_d, eff_state_s;
   logic             row_end_s, frame_end_s, emit_s, k0_zero_s, k1_zero_s;
   logic [PW-1:0]    lb0_rd_s, lb1_rd_s, lb0_sel_s, lb1_sel_s;
   logic [OW-1:0]    col_pkt_s;
   logic             valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
   logic [OW-1:0]    data_q, data_d;
   logic [COL_W-1:0] col_out_q, col_out_d;

   dw_lb_bank #(.DEPTH(IMG_WIDTH), .WIDTH(PW), .AW(COL_W)) u_lb0 (
      .clk   (clk),
      .we    (valid_in),
      .addr  (eff_col_s),
      .wdata (lb1_rd_s),
      .rdata (lb0_rd_s)
   );

   dw_lb_bank #(.DEPTH(IMG_WIDTH), .WIDTH(PW), .AW(COL_W)) u_lb1 (
      .clk   (clk),
      .we    (valid_in),
      .addr  (eff_col_s),
      .wdata (data_in),
      .rdata (lb1_rd_s)
   );

   // sof_in restarts the frame for this very pixel, even mid-row
   always_comb begin
      if (sof_in) begin
         eff_col_s   = '0;
         eff_row_s   = '0;
         eff_state_s = ST_FILL;
      end else begin
         eff_col_s   = col_q;
         eff_row_s   = row_q;
         eff_state_s = state_q;
      end
      row_end_s   = (eff_col_s == COL_LAST);
      frame_end_s = row_end_s && (eff_row_s == ROW_LAST);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_in) begin
         if (row_end_s) begin
            col_d = '0;
            if (eff_row_s == ROW_LAST) begin
               row_d = '0;
            end else begin
               row_d = eff_row_s + ROW_W'(1);
            end
         end else begin
            col_d = eff_col_s + COL_W'(1);
            row_d = eff_row_s;
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (valid_in) begin
         case (eff_state_s)
            ST_FILL: begin
               if (row_end_s && (eff_row_s == ROW_W'(1))) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_STREAM: begin
               if (frame_end_s) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_STREAM;
               end
            end
            default: state_d = ST_FILL;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
`ifdef DW_LB_ZERO_PAD_EN
      emit_s    = valid_in;
      k0_zero_s = (eff_state_s == ST_FILL);
      k1_zero_s = (eff_state_s == ST_FILL) && (eff_row_s == ROW_W'(0));
`else
      emit_s    = valid_in && (eff_state_s == ST_STREAM);
      k0_zero_s = 1'b0;
      k1_zero_s = 1'b0;
`endif
      lb0_sel_s = k0_zero_s ? '0 : lb0_rd_s;
      lb1_sel_s = k1_zero_s ? '0 : lb1_rd_s;
   end

   // Pack oldest row into k=0, current pixel into k=2
   always_comb begin
      col_pkt_s = '0;
      for (int j = 0; j < CH; j++) begin
         col_pkt_s[dw_slot_off(j, 0, DATA_WIDTH) +: DATA_WIDTH] = lb0_sel_s[j*DATA_WIDTH +: DATA_WIDTH];
         col_pkt_s[dw_slot_off(j, 1, DATA_WIDTH) +: DATA_WIDTH] = lb1_sel_s[j*DATA_WIDTH +: DATA_WIDTH];
         col_pkt_s[dw_slot_off(j, 2, DATA_WIDTH) +: DATA_WIDTH] = data_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Output decode; data and column hold when nothing is emitted
   always_comb begin
      valid_d = emit_s;
      eol_d   = emit_s && row_end_s;
      eof_d   = emit_s && frame_end_s;
      if (emit_s) begin
         data_d    = col_pkt_s;
         col_out_d = eff_col_s;
      end else begin
         data_d    = data_q;
         col_out_d = col_out_q;
      end
   end

   // State, counters and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FILL;
         col_q     <= '0;
         row_q     <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         col_out_q <= '0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         col_out_q <= col_out_d;
         eol_q     <= eol_d;
         eof_q     <= eof_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign col_out   = col_out_q;
   assign eol_out   = eol_q;
   assign eof_out   = eof_q;

endmodule

// File: tb/tb_dw_line_buffer.sv
// Self-checking bench for dw_line_buffer (CH=2, 8-bit, 4x4 image); frame-level
// vectors come from a table, per-pixel expectations flow through a scoreboard.
module tb_dw_line_buffer;

   localparam int CH = 2;
   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;
`ifdef DW_LB_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int EXP_V   = PAD ? 16 : 8;
   localparam int EXP_EOL = PAD ? 4 : 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        valid_in, sof_in;
   logic [47:0] data_out;
   logic        valid_out;
   logic [1:0]  col_out;
   logic        eol_out, eof_out;

   always #5 clk = ~clk;

   dw_line_buffer #(.CH(CH), .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .sof_in    (sof_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .col_out   (col_out),
      .eol_out   (eol_out),
      .eof_out   (eof_out)
   );

   typedef struct {
      logic        v;
      logic [47:0] d;
      logic [1:0]  c;
      logic        eol;
      logic        eof;
   } exp_t;

   typedef struct {
      bit         sof;
      int         gap;
      int         base;
      logic [7:0] mask;
      int         exp_v;
      int         exp_eol;
      int         exp_eof;
   } vec_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] img [H][W];
   int          mr, mc;
   logic [47:0] last_d;
   int          n_v, n_eol, n_eof;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] pix(input int base, input int r, input int c, input logic [7:0] mask);
      logic [7:0] v8;
      v8 = 8'(base + r * 16 + c);
      return {v8 ^ mask, v8};
   endfunction

   task automatic step(input logic v, input logic s, input logic [15:0] d);
      exp_t e;
      logic [7:0] k0, k1;
      @(negedge clk);
      valid_in = v;
      sof_in   = s;
      data_in  = d;
      e.v = 1'b0; e.d = last_d; e.c = 2'd0; e.eol = 1'b0; e.eof = 1'b0;
      if (v) begin
         if (s) begin
            mr = 0;
            mc = 0;
         end
         img[mr][mc] = d;
         if (PAD || mr >= 2) begin
            e.v   = 1'b1;
            e.c   = 2'(mc);
            e.eol = (mc == W - 1);
            e.eof = (mc == W - 1) && (mr == H - 1);
            for (int j = 0; j < CH; j++) begin
               k0 = 8'h00;
               k1 = 8'h00;
               if (mr >= 2) k0 = img[mr-2][mc][j*8 +: 8];
               if (mr >= 1) k1 = img[mr-1][mc][j*8 +: 8];
               e.d[(j*3+0)*8 +: 8] = k0;
               e.d[(j*3+1)*8 +: 8] = k1;
               e.d[(j*3+2)*8 +: 8] = d[j*8 +: 8];
            end
            last_d = e.d;
         end
         if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end else begin
            mc = mc + 1;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_v   += int'(valid_out);
      n_eol += int'(eol_out);
      n_eof += int'(eof_out);
      chk("valid_out", 64'(valid_out), 64'(e.v));
      chk("eol_out", 64'(eol_out), 64'(e.eol));
      chk("eof_out", 64'(eof_out), 64'(e.eof));
      chk("data_out", 64'(data_out), 64'(e.d));
      if (e.v) chk("col_out", 64'(col_out), 64'(e.c));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " valid_out"}, 64'(valid_out), 64'd0);
      chk({tag, " data_out"}, 64'(data_out), 64'd0);
      chk({tag, " col_out"}, 64'(col_out), 64'd0);
      chk({tag, " eol_out"}, 64'(eol_out), 64'd0);
      chk({tag, " eof_out"}, 64'(eof_out), 64'd0);
   endtask

   vec_t tbl[4];

   initial begin
      int v0, e0, f0;
      tbl[0] = '{sof: 1'b1, gap: 0, base: 8'h00, mask: 8'h00, exp_v: EXP_V, exp_eol: EXP_EOL, exp_eof: 1};
      tbl[1] = '{sof: 1'b1, gap: 1, base: 8'h00, mask: 8'h00, exp_v: EXP_V, exp_eol: EXP_EOL, exp_eof: 1};
      tbl[2] = '{sof: 1'b0, gap: 0, base: 8'h80, mask: 8'h5A, exp_v: EXP_V, exp_eol: EXP_EOL, exp_eof: 1};
      tbl[3] = '{sof: 1'b1, gap: 0, base: 8'h30, mask: 8'hFF, exp_v: EXP_V, exp_eol: EXP_EOL, exp_eof: 1};

      rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; data_in = 16'h0000;
      mr = 0; mc = 0; last_d = 48'h0; n_v = 0; n_eol = 0; n_eof = 0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         v0 = n_v; e0 = n_eol; f0 = n_eof;
         for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
               step(1'b1, tbl[i].sof && r == 0 && c == 0, pix(tbl[i].base, r, c, tbl[i].mask));
`ifdef DW_LB_ZERO_PAD_EN
               if (i == 0 && r == 0 && c == 1) chk("pad pix01 ch0", 64'(data_out[23:0]), 64'h010000);
               if (i == 0 && r == 1 && c == 2) chk("pad pix12 ch0", 64'(data_out[23:0]), 64'h120200);
`else
               if (i == 0 && r == 2 && c == 0) chk("pix20 ch0", 64'(data_out[23:0]), 64'h201000);
               if (i == 2 && r == 2 && c == 0) chk("frame2 first ch0", 64'(data_out[23:0]), 64'hA09080);
`endif
               for (int g = 0; g < tbl[i].gap; g++) step(1'b0, 1'b0, 16'($urandom));
            end
         end
         chk("frame valid count", 64'(n_v - v0), 64'(tbl[i].exp_v));
         chk("frame eol count", 64'(n_eol - e0), 64'(tbl[i].exp_eol));
         chk("frame eof count", 64'(n_eof - f0), 64'(tbl[i].exp_eof));
      end

      // Resync: sof arrives where pixel (2,1) would have been
      for (int p = 0; p < 9; p++) step(1'b1, p == 0, pix(8'h10, p / W, p % W, 8'h00));
      v0 = n_v;
      for (int p = 0; p < 16; p++) begin
         step(1'b1, p == 0, pix(8'h90, p / W, p % W, 8'h33));
         if (p == 7) chk("resync fill valids", 64'(n_v - v0), 64'(PAD ? 8 : 0));
      end
      chk("resync frame valids", 64'(n_v - v0), 64'(EXP_V));

      // Async reset mid-frame at (3,2), then a fresh frame without sof
      for (int p = 0; p < 14; p++) step(1'b1, p == 0, pix(8'h20, p / W, p % W, 8'h0F));
      chk("pre-reset valid_out", 64'(valid_out), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async reset");
      valid_in = 1'b0;
      sof_in   = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mr = 0; mc = 0; last_d = 48'h0;
      sb.delete();
      v0 = n_v; e0 = n_eol; f0 = n_eof;
      for (int p = 0; p < 16; p++) step(1'b1, 1'b0, pix(8'h50, p / W, p % W, 8'h77));
      chk("post-reset valids", 64'(n_v - v0), 64'(EXP_V));
      chk("post-reset eol count", 64'(n_eol - e0), 64'(EXP_EOL));
      chk("post-reset eof count", 64'(n_eof - f0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
